// File: rtl/pong_pkg.sv
// pong_pkg: shared constants, state type and reply-byte helper for the pong joystick link
//   JSTK_FRAME_BYTES  bytes in one joystick SPI frame
//   JSTK_LED_CMD_BIT  command-byte bit that enables the LED update
//   JSTK_XY_BITS      width of the X/Y positions
//   jstk_state_t      responder FSM states
//   jstk_tx_byte      reply byte for a given frame index
package pong_pkg;
    localparam int JSTK_FRAME_BYTES = 5;
    localparam int JSTK_LED_CMD_BIT = 7;
    localparam int JSTK_XY_BITS = 10;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} jstk_state_t;

    // Indices at or past the frame length read as zero so overlong frames clock out 00.
    function automatic logic [7:0] jstk_tx_byte(
        input logic [2:0] idx,
        input int frame_bytes,
        input logic [JSTK_XY_BITS-1:0] x,
        input logic [JSTK_XY_BITS-1:0] y,
        input logic [2:0] b
    );
        if (int'(idx) >= frame_bytes)
            return 8'h00;
        return idx == 3'd0 ? x[7:0] :
               idx == 3'd1 ? {6'b0, x[9:8]} :
               idx == 3'd2 ? y[7:0] :
               idx == 3'd3 ? {6'b0, y[9:8]} :
               idx == 3'd4 ? {5'b0, b} : 8'h00;
    endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-stage synchronizer with one-cycle rise/fall strobes
//   clk50M  system clock
//   reset   asynchronous, active-high
//   din     asynchronous input pin
//   sync    synchronized level
//   rise    one-cycle strobe on a synchronized 0->1
//   fall    one-cycle strobe on a synchronized 1->0
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk50M,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic prev;

    always_ff @(posedge clk50M or posedge reset)
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI-slave emulation of the PmodJSTK joystick (mode 0, 5-byte frames)
//   clk50M, reset        system clock, asynchronous active-high reset
//   cs_n, sck, mosi      SPI pins from the master, asynchronous to clk50M
//   miso                 reply data, MSB first, registered
//   joy_x, joy_y         positions snapshotted at each cs_n fall
//   buttons              {trigger, btn2, btn1}, snapshotted with the positions
//   led                  last LED state commanded in a valid frame
//   frame_done/frame_err one-cycle pulses at the end of a valid / invalid frame
module jstk_spi_responder import pong_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = JSTK_FRAME_BYTES
) (
    input  logic                    clk50M,
    input  logic                    reset,
    input  logic                    cs_n,
    input  logic                    sck,
    input  logic                    mosi,
    output logic                    miso,
    input  logic [JSTK_XY_BITS-1:0] joy_x,
    input  logic [JSTK_XY_BITS-1:0] joy_y,
    input  logic [2:0]              buttons,
    output logic [1:0]              led,
    output logic                    frame_done,
    output logic                    frame_err
);
    localparam logic [5:0] FRAME_BITS = 6'(8 * FRAME_BYTES);

    logic cs_s, cs_rise, cs_fall;
    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clk50M(clk50M), .reset(reset), .din(cs_n), .sync(cs_s), .rise(cs_rise), .fall(cs_fall));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk50M(clk50M), .reset(reset), .din(sck), .sync(sck_s), .rise(sck_rise), .fall(sck_fall));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk50M(clk50M), .reset(reset), .din(mosi), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_sync = sck_s ^ mosi_rise ^ mosi_fall;

    jstk_state_t state;
    logic [5:0] bit_cnt;
    logic [2:0] byte_cnt;
    logic [7:0] tx_sr;
    logic [6:0] rx_sr;
    logic cmd_led_en;
    logic [1:0] cmd_led;
    logic [JSTK_XY_BITS-1:0] snap_x, snap_y;
    logic [2:0] snap_b;
    logic [2:0] next_idx;
    logic [7:0] first_byte, next_byte;

    // Byte index saturates with the bit counter so a runaway frame never wraps back to byte0.
    assign next_idx   = byte_cnt == 3'd7 ? 3'd7 : byte_cnt + 3'd1;
    assign first_byte = jstk_tx_byte(3'd0, FRAME_BYTES, joy_x, joy_y, buttons);
    assign next_byte  = jstk_tx_byte(next_idx, FRAME_BYTES, snap_x, snap_y, snap_b);

    always_ff @(posedge clk50M or posedge reset)
        if (reset) begin
            state      <= WAIT_IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            cmd_led_en <= 1'b0;
            cmd_led    <= '0;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_b     <= '0;
            miso       <= 1'b0;
            led        <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                // A frame already running when reset releases is skipped until cs_n goes high.
                WAIT_IDLE: if (cs_s) state <= IDLE;
                IDLE: if (cs_fall) begin
                    snap_x   <= joy_x;
                    snap_y   <= joy_y;
                    snap_b   <= buttons;
                    tx_sr    <= first_byte;
                    miso     <= first_byte[7];
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    state    <= SHIFT;
                end
                SHIFT:
                    // cs_n rise wins over an sck strobe in the same cycle; that sck edge is dropped.
                    if (cs_rise) begin
                        state <= IDLE;
                        miso  <= 1'b0;
                        if (bit_cnt == FRAME_BITS) begin
                            frame_done <= 1'b1;
                            if (cmd_led_en) led <= cmd_led;
                        end else
                            frame_err <= 1'b1;
                    end else if (sck_rise) begin
                        rx_sr   <= {rx_sr[5:0], mosi_s};
                        bit_cnt <= bit_cnt == 6'd63 ? 6'd63 : bit_cnt + 6'd1;
                        // The eighth bit completes the command byte.
                        if (bit_cnt == 6'd7) begin
                            cmd_led_en <= rx_sr[JSTK_LED_CMD_BIT-1];
                            cmd_led    <= {rx_sr[0], mosi_s};
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt[2:0] != 3'd0) begin
                            tx_sr <= {tx_sr[6:0], 1'b0};
                            miso  <= tx_sr[6];
                        end else begin
                            tx_sr    <= next_byte;
                            miso     <= next_byte[7];
                            byte_cnt <= next_idx;
                        end
                    end
                default: state <= WAIT_IDLE;
            endcase
        end
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: directed and random SPI frames checked against a frame-level reference model
module tb_jstk_spi_responder;
    logic clk50M = 1'b0;
    logic reset, cs_n, sck, mosi, miso;
    logic [9:0] joy_x, joy_y;
    logic [2:0] buttons;
    logic [1:0] led;
    logic frame_done, frame_err;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [1:0] led_exp = 2'b00;

    jstk_spi_responder dut (
        .clk50M(clk50M), .reset(reset), .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso),
        .joy_x(joy_x), .joy_y(joy_y), .buttons(buttons), .led(led),
        .frame_done(frame_done), .frame_err(frame_err));

    always #10 clk50M = ~clk50M;

    always @(negedge clk50M) begin
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One master frame of nbits at 1 MHz. cmd0 goes out as the first MOSI byte, the rest are zero.
    // chg_at: bit at which joy_x is replaced by chg_x; rst_at: bit at which reset is pulsed (-1 = never).
    task automatic frame(input string name, input logic [7:0] cmd0, input int nbits,
                         input int chg_at, input logic [9:0] chg_x, input int rst_at);
        logic [7:0] rx [8];
        logic [7:0] exp_b [8];
        int x, y;
        bit done_exp;
        x = int'(joy_x);
        y = int'(joy_y);
        exp_b[0] = 8'(x % 256);
        exp_b[1] = 8'(x / 256);
        exp_b[2] = 8'(y % 256);
        exp_b[3] = 8'(y / 256);
        exp_b[4] = {5'b0, buttons};
        for (int k = 5; k < 8; k++) exp_b[k] = 8'h00;
        for (int k = 0; k < 8; k++) rx[k] = 8'h00;
        done_cnt = 0;
        err_cnt = 0;
        cs_n = 1'b0;
        #1000;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) joy_x = chg_x;
            if (i == rst_at) begin
                reset = 1'b1;
                #1;
                check({name, " rst miso"}, 32'(miso), 0);
                check({name, " rst led"}, 32'(led), 0);
                check({name, " rst done"}, 32'(frame_done), 0);
                check({name, " rst err"}, 32'(frame_err), 0);
                #40 reset = 1'b0;
                led_exp = 2'b00;
            end
            mosi = i < 8 ? cmd0[7 - i] : 1'b0;
            #500 sck = 1'b1;
            rx[i / 8][7 - (i % 8)] = miso;
            #500 sck = 1'b0;
        end
        #500 cs_n = 1'b1;
        mosi = 1'b0;
        #300;
        for (int k = 0; k < nbits / 8; k++)
            if (rst_at < 0 || (k + 1) * 8 <= rst_at)
                check($sformatf("%s byte%0d", name, k), 32'(rx[k]), 32'(exp_b[k]));
            else if (k * 8 >= rst_at)
                check($sformatf("%s byte%0d after reset", name, k), 32'(rx[k]), 0);
        done_exp = rst_at < 0 && nbits == 40;
        if (done_exp && cmd0[7]) led_exp = cmd0[1:0];
        check({name, " done pulses"}, 32'(done_cnt), 32'(done_exp));
        check({name, " err pulses"}, 32'(err_cnt), 32'(rst_at < 0 && !done_exp));
        check({name, " led"}, 32'(led), 32'(led_exp));
        check({name, " idle miso"}, 32'(miso), 0);
        #200;
    endtask

    initial begin
        reset = 1'b1;
        cs_n = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        joy_x = 10'h2A5;
        joy_y = 10'h17C;
        buttons = 3'b101;
        #53;
        check("reset miso", 32'(miso), 0);
        check("reset led", 32'(led), 0);
        check("reset done", 32'(frame_done), 0);
        check("reset err", 32'(frame_err), 0);
        #50 reset = 1'b0;
        #300;
        frame("nominal", 8'h83, 40, -1, 10'h0, -1);
        frame("no led bit", 8'h03, 40, -1, 10'h0, -1);
        frame("snapshot", 8'h00, 40, 10, 10'h3FF, -1);
        frame("after snapshot", 8'h00, 40, -1, 10'h0, -1);
        frame("short", 8'h81, 17, -1, 10'h0, -1);
        frame("empty", 8'h80, 0, -1, 10'h0, -1);
        frame("overlong", 8'h82, 48, -1, 10'h0, -1);
        frame("reset mid", 8'h83, 40, -1, 10'h0, 20);
        frame("after reset", 8'h82, 40, -1, 10'h0, -1);
        for (int n = 0; n < 10; n++) begin
            joy_x = 10'($urandom_range(0, 1023));
            joy_y = 10'($urandom_range(0, 1023));
            buttons = 3'($urandom_range(0, 7));
            frame($sformatf("rand%0d", n), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 48)) : 40, -1, 10'h0, -1);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/jstk_spi_responder.md
# jstk_spi_responder

SPI-slave emulation of the PmodJSTK joystick. It answers the 5-byte frames issued by the pong joystick paddle SPI master: X, Y and buttons go out on MISO, and the LED command byte on MOSI is captured. Used as the far end of the paddle link in board-to-board play and as the bench model for the joystick paddle path. All logic runs in the clk50M domain; SPI pins are oversampled.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `cs_n`, `sck` and `mosi` (at least 2).
- `FRAME_BYTES`, default 5: bytes per valid frame.
- `clk50M` in, 1: system clock, 50 MHz.
- `reset` in, 1: asynchronous, active-high.
- `cs_n` in, 1: SPI chip select, active low, asynchronous to `clk50M`.
- `sck` in, 1: SPI clock, mode 0, at most 1 MHz, idle low.
- `mosi` in, 1: master data, MSB first.
- `miso` out, 1: slave data, MSB first.
- `joy_x` in, 10: X position to report, 0..1023.
- `joy_y` in, 10: Y position to report, 0..1023.
- `buttons` in, 3: {trigger, btn2, btn1}, active high.
- `led` out, 2: last LED state commanded by the master.
- `frame_done` out, 1: one-cycle pulse when a valid frame ends.
- `frame_err` out, 1: one-cycle pulse when a frame is aborted or overlong.

## Operation
- Reset values: `miso`=0, `led`=2'b00, `frame_done`=0, `frame_err`=0, state=WAIT_IDLE, all counters 0.
- The design only uses synchronized `cs_n`, `sck` and `mosi`, plus one-cycle fall/rise strobes derived from the synchronized signals.
- **WAIT_IDLE**
  - Entered at reset.
  - Go to IDLE once synced `cs_n`=1. This ensures a frame already in progress at reset release is ignored.
- **IDLE**
  - `miso`=0.
  - On `cs_n` fall:
    - Snapshot `joy_x`, `joy_y` and `buttons` into the TX registers.
    - Load byte0 into the shift register and drive its MSB on `miso`.
    - Clear the bit and byte counters, then go to SHIFT.
- **TX byte order**
  - byte0 = `joy_x[7:0]`
  - byte1 = {6'b0, `joy_x[9:8]`}
  - byte2 = `joy_y[7:0]`
  - byte3 = {6'b0, `joy_y[9:8]`}
  - byte4 = {5'b0, `buttons`}
  - Any byte index at or above `FRAME_BYTES` is 8'h00.
- **SHIFT**
  - `sck` rise:
    - Shift synced `mosi` into the RX register.
    - Increment the bit counter, which is 6 bits and saturates at 63.
  - `sck` fall:
    - If the bit count is not a multiple of 8, shift the TX register and drive the next bit.
    - If it is a multiple of 8, load the next byte and drive its MSB.
  - When the bit count reaches 8, latch the RX register as `cmd_byte`.
  - `cs_n` rise: go to IDLE. In the same cycle:
    - If bit count == 8×`FRAME_BYTES`, pulse `frame_done`. If `cmd_byte[7]`=1, also update `led` <= `cmd_byte[1:0]`; otherwise `led` is unchanged.
    - Any other count (including 0) pulses `frame_err` and leaves `led` unchanged.
- **Simultaneous strobes**: `cs_n` rise takes priority over any `sck` strobe in the same cycle, and that `sck` edge is discarded.
- **Snapshot**: input changes during a frame have no effect on the bytes sent until the next `cs_n` fall.

## Timing
- Strobe latency is `SYNC_STAGES`+1 `clk50M` cycles after the pin edge (3 with the default).
- `miso` after a `sck` fall: updates 3 cycles after the pin edge, 60 ns. This is well inside the 500 ns half-period at 1 MHz.
- `miso` first bit: valid 3 cycles after `cs_n` fall. The master must allow at least 100 ns from `cs_n` fall to the first `sck` rise; the joystick master already allows 15 µs.
- `frame_done`, `frame_err` and `led` update 3 cycles after the `cs_n` rising pin edge.
- Back-to-back frames: `cs_n` high for at least 4 `clk50M` cycles is sufficient. A shorter high pulse may go unseen by the synchronizer. In that case the two frames merge and produce `frame_err`.
- Output registers: `miso`, `led`, `frame_done` and `frame_err` are all registered, with no combinational path from the pins.

## Structure
- **Shared `pong_pkg`**:
  - `JSTK_FRAME_BYTES`=5
  - `JSTK_LED_CMD_BIT`=7
  - `JSTK_XY_BITS`=10
  - the state enum {WAIT_IDLE, IDLE, SHIFT}
- **Sub-module `sync_edge_detect`**:
  - `SYNC_STAGES`-deep flop chain, with outputs `sync`, `rise` and `fall`.
  - Instantiated three times: `cs_n`, `sck`, `mosi`. Only `sync` is used for `mosi`.
  - Reusable elsewhere for button and encoder inputs.
- **Top level** contains the FSM, the bit and byte counters, the TX/RX shift registers and the snapshot registers. Expected size is about 200 lines.

## Test plan
- **Nominal frame**
  - Stimulus: `joy_x`=10'h2A5, `joy_y`=10'h17C, `buttons`=3'b101; master sends 8'h83,00,00,00,00 at 1 MHz.
  - Response: MISO bytes A5,02,7C,01,05; `frame_done` pulses once; `led`=2'b11.
- **Command without LED bit**
  - Stimulus: command 8'h03 with `cmd_byte[7]`=0.
  - Response: `frame_done` pulses; `led` keeps its previous value 2'b11.
- **Snapshot hold**
  - Stimulus: change `joy_x` to 10'h3FF during byte1.
  - Response: bytes are still A5,02; the next frame returns FF,03.
- **Short frame**
  - Stimulus: `cs_n` rises after 17 bits.
  - Response: `frame_err` pulses once; no `frame_done`; `led` unchanged.
- **Overlong frame**
  - Stimulus: 6 bytes are clocked.
  - Response: byte5 is 00; `frame_err` pulses; `led` unchanged.
- **Reset mid-frame**
  - Stimulus: assert `reset` during byte2, then release it while `cs_n` is still low.
  - Response: all outputs return to their reset values; the rest of that frame is ignored (no pulses); the next full frame returns correct data.
